// File: rtl/clock_display_scan_if.sv
// Display bus between the time counter / board pins and the digit scanner.
// Latency: none (wires only).
// Backpressure: none; the scanner samples digits on its own schedule.
interface clock_display_scan_if;
    logic [3:0] sl;
    logic [3:0] sm;
    logic [3:0] ml;
    logic [3:0] mm;
    logic [3:0] hl;
    logic [3:0] hm;
    logic       lz_blank;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    // Time source side: drives BCD digits, observes the display pins.
    modport master (
        output sl, sm, ml, mm, hl, hm, lz_blank,
        input  an, seg, dp
    );

    // Scanner side: consumes BCD digits, drives the display pins.
    modport slave (
        input  sl, sm, ml, mm, hl, hm, lz_blank,
        output an, seg, dp
    );
endinterface

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed seven-segment scanner with per-frame coherent digit snapshot.
// Latency: outputs lag prescaler/index by 1 clk; input change visible within 12*SCAN_DIV+1 clks.
// Backpressure: none; free-running scan, inputs sampled only at frame wrap (or after reset).
module clock_display_scan #(
    parameter int SCAN_DIV = 1000,
    parameter int GUARD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    clock_display_scan_if.slave   disp
);

    typedef struct packed {
        logic [3:0] hm;
        logic [3:0] hl;
        logic [3:0] mm;
        logic [3:0] ml;
        logic [3:0] sm;
        logic [3:0] sl;
    } digits_t;

    localparam logic [15:0] P_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] P_GUARD = 16'(GUARD);

    logic [15:0] p;
    logic [2:0]  i;
    logic        load_pend;
    digits_t     live;
    digits_t     shadow;
    digits_t     view;
    logic        slot_end;
    logic        frame_wrap;

    logic [3:0]  cur_digit;
    logic [5:0]  an_nxt;
    logic [6:0]  seg_nxt;
    logic        dp_nxt;

    logic [5:0]  an_q;
    logic [6:0]  seg_q;
    logic        dp_q;

    assign live       = {disp.hm, disp.hl, disp.mm, disp.ml, disp.sm, disp.sl};
    assign slot_end   = (p == P_LAST);
    assign frame_wrap = slot_end && (i == 3'd5);

    // The first slot after reset decodes straight from the live inputs, since the
    // shadow is being loaded on that same edge; otherwise only the shadow is shown,
    // so a frame never mixes digits from two sample instants.
    assign view = load_pend ? live : shadow;

    // Prescaler and digit index: one slot per SCAN_DIV cycles, six slots per frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p <= '0;
            i <= '0;
        end else if (slot_end) begin
            p <= '0;
            i <= (i == 3'd5) ? 3'd0 : i + 3'd1;
        end else begin
            p <= p + 16'd1;
        end
    end

    // Snapshot all six digits at frame wrap, or once right after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow    <= '0;
            load_pend <= 1'b1;
        end else begin
            if (load_pend || frame_wrap) begin
                shadow <= live;
            end
            load_pend <= 1'b0;
        end
    end

    // Select the active digit, decode it, and apply guard, blanking and colon rules.
    always_comb begin
        cur_digit = view.sl;
        an_nxt    = '0;
        seg_nxt   = '0;
        dp_nxt    = 1'b0;

        case (i)
            3'd0:    cur_digit = view.sl;
            3'd1:    cur_digit = view.sm;
            3'd2:    cur_digit = view.ml;
            3'd3:    cur_digit = view.mm;
            3'd4:    cur_digit = view.hl;
            3'd5:    cur_digit = view.hm;
            default: cur_digit = view.sl;
        endcase

        case (cur_digit)
            4'd0:    seg_nxt = 7'h3F;
            4'd1:    seg_nxt = 7'h06;
            4'd2:    seg_nxt = 7'h5B;
            4'd3:    seg_nxt = 7'h4F;
            4'd4:    seg_nxt = 7'h66;
            4'd5:    seg_nxt = 7'h6D;
            4'd6:    seg_nxt = 7'h7D;
            4'd7:    seg_nxt = 7'h07;
            4'd8:    seg_nxt = 7'h7F;
            4'd9:    seg_nxt = 7'h6F;
            default: seg_nxt = 7'h40;
        endcase

        if ((i == 3'd5) && disp.lz_blank && (view.hm == 4'd0)) begin
            seg_nxt = 7'h00;
        end

        an_nxt = (p < P_GUARD) ? 6'd0 : (6'd1 << i);
        dp_nxt = ((i == 3'd2) || (i == 3'd4)) && !view.sl[0];

        // Segments never light without a digit enable.
        if (an_nxt == 6'd0) begin
            seg_nxt = 7'h00;
            dp_nxt  = 1'b0;
        end
    end

    // Output pin registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_q  <= '0;
            seg_q <= '0;
            dp_q  <= 1'b0;
        end else begin
            an_q  <= an_nxt;
            seg_q <= seg_nxt;
            dp_q  <= dp_nxt;
        end
    end

    assign disp.an  = an_q;
    assign disp.seg = seg_q;
    assign disp.dp  = dp_q;

endmodule

// File: tb/tb_clock_display_scan.sv
module tb_clock_display_scan;

    localparam int SD = 4;
    localparam int GD = 1;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    exp_t q[$];

    clock_display_scan_if dif();

    clock_display_scan #(.SCAN_DIV(SD), .GUARD(GD)) dut (
        .clk  (clk),
        .rst  (rst),
        .disp (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] dec7(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // d = {hm,hl,mm,ml,sm,sl}
    task automatic set_inputs(input logic [23:0] d, input logic lz);
        dif.sl       = d[3:0];
        dif.sm       = d[7:4];
        dif.ml       = d[11:8];
        dif.mm       = d[15:12];
        dif.hl       = d[19:16];
        dif.hm       = d[23:20];
        dif.lz_blank = lz;
    endtask

    // Expected outputs for one frame of 6*SD edges, starting at a frame boundary.
    task automatic push_frame(input logic [23:0] d, input logic lz);
        exp_t e;
        logic [3:0] v;
        for (int s = 0; s < 6; s++) begin
            v = d[4*s +: 4];
            for (int ph = 0; ph < SD; ph++) begin
                e = '0;
                if (ph >= GD) begin
                    e.an  = 6'd1 << s;
                    e.seg = (s == 5 && lz && v == 4'd0) ? 7'h00 : dec7(v);
                    e.dp  = (s == 2 || s == 4) && !d[0];
                end
                q.push_back(e);
            end
        end
    endtask

    task automatic check_cycles(input int n, input string name);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL %s cycle %0d: scoreboard empty, got an=%b seg=%h dp=%b",
                         name, c, dif.an, dif.seg, dif.dp);
            end else begin
                e = q.pop_front();
                if ({dif.an, dif.seg, dif.dp} !== {e.an, e.seg, e.dp}) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                             name, c, dif.an, dif.seg, dif.dp, e.an, e.seg, e.dp);
                end
            end
        end
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if ({dif.an, dif.seg, dif.dp} !== 14'd0) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%h dp=%b, expected all 0",
                     name, dif.an, dif.seg, dif.dp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_inputs(24'h235958, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset_state");
        rst = 1'b1;
        #1;
        check_zero_outputs("reset_release_before_edge");
    endtask

    task automatic test_frame();
        push_frame(24'h235958, 1'b0);
        check_cycles(6 * SD, "frame_235958");
    endtask

    task automatic test_snapshot();
        push_frame(24'h235958, 1'b0);
        push_frame(24'h000000, 1'b0);
        check_cycles(2 * SD + 2, "snap_before_change");
        set_inputs(24'h000000, 1'b0);
        check_cycles(10 * SD - 2, "snap_after_change");
    endtask

    task automatic test_lz_blank();
        set_inputs(24'h071234, 1'b1);
        push_frame(24'h000000, 1'b1);
        push_frame(24'h071234, 1'b1);
        check_cycles(12 * SD, "lz_blank_on");
        set_inputs(24'h071234, 1'b0);
        push_frame(24'h071234, 1'b0);
        check_cycles(6 * SD, "lz_blank_off");
    endtask

    task automatic test_invalid_and_colon();
        set_inputs(24'h07123C, 1'b0);
        push_frame(24'h071234, 1'b0);
        push_frame(24'h07123C, 1'b0);
        check_cycles(12 * SD, "invalid_digit");
        set_inputs(24'h071239, 1'b0);
        push_frame(24'h07123C, 1'b0);
        push_frame(24'h071239, 1'b0);
        check_cycles(12 * SD, "odd_second_colon");
    endtask

    task automatic test_reset_mid_frame();
        push_frame(24'h071239, 1'b0);
        check_cycles(3 * SD + 2, "pre_reset_slot3");
        q.delete();
        rst = 1'b0;
        #1;
        check_zero_outputs("async_reset_mid_slot");
        set_inputs(24'h124530, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_zero_outputs("held_in_reset");
        rst = 1'b1;
        push_frame(24'h124530, 1'b0);
        check_cycles(6 * SD, "restart_after_reset");
    endtask

    task automatic test_random_invariants();
        logic onehot0;
        for (int c = 0; c < 50 * 6 * SD; c++) begin
            @(posedge clk);
            @(negedge clk);
            onehot0 = (dif.an & (dif.an - 6'd1)) == 6'd0;
            checks++;
            if (!onehot0) begin
                errors++;
                $display("FAIL rand_onehot cycle %0d: got an=%b, required zero or one-hot", c, dif.an);
            end
            checks++;
            if (dif.an == 6'd0 && (dif.seg != 7'h00 || dif.dp != 1'b0)) begin
                errors++;
                $display("FAIL rand_dark cycle %0d: got seg=%h dp=%b with an=0, required seg=00 dp=0",
                         c, dif.seg, dif.dp);
            end
            set_inputs(24'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_frame();
        test_snapshot();
        test_lz_blank();
        test_invalid_and_colon();
        test_reset_mid_frame();
        test_random_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_display_scan.md
# clock_display_scan

Multiplexed six-digit seven-segment scanner for the 24-hour clock. It reads the six BCD time digits produced by the clock counter (seconds, minutes and hours, low and high) and drives one shared segment bus plus six digit enables.
- Each display frame takes a coherent snapshot of all six digits, so no digit tears during a carry.
- Applies a ghosting guard at each digit change, optional leading-zero blanking of the hours-tens digit, and a colon that blinks with the seconds.
- Sits between the time counter and the board display pins.

## Interface
- SCAN_DIV, 1000: clk cycles per digit slot; legal range 2..65535.
- GUARD, 2: cycles at the start of each slot with all digit enables off; 0 ≤ GUARD < SCAN_DIV.
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- sl  in  4  BCD seconds units.
- sm  in  4  BCD seconds tens.
- ml  in  4  BCD minutes units.
- mm  in  4  BCD minutes tens.
- hl  in  4  BCD hours units.
- hm  in  4  BCD hours tens.
- lz_blank  in  1  when 1, the hm digit shows blank if its snapshot value is 0.
- an  out  6  digit enables, one-hot, active-high: an[0]=sl … an[5]=hm.
- seg  out  7  segments, active-high, seg[6:0] = {g,f,e,d,c,b,a}.
- dp  out  1  decimal point / colon segment, active-high.

## Operation
- **Prescaler p**
  - Counts 0..SCAN_DIV-1.
  - At p==SCAN_DIV-1: p←0 and index i advances 0→1→…→5→0.
  - Otherwise p←p+1.
- **Snapshot**
  - A six-digit shadow register loads all inputs on the edge where p==SCAN_DIV-1 and i==5 (frame wrap).
  - It also loads on the first rising edge after rst deasserts (load-pending flag set by reset).
  - Inputs are never sampled at any other time.
- **Digit mapping**: i=0 sl, 1 sm, 2 ml, 3 mm, 4 hl, 5 hm.
- **Decode** (hex on seg)
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any value 10..15 shows 40 (dash, g only).
- **Leading-zero blank**: if i==5, lz_blank==1 and shadow hm==0, then seg=00. an is still driven.
- **Colon**: dp=1 iff an is nonzero, i∈{2,4}, and shadow sl[0]==0. The colon is lit on even seconds.
- **Output registers**
  - an, seg and dp are registered from the current p, i and shadow.
  - an ← (p<GUARD) ? 0 : (1<<i).
  - seg and dp ← 0 whenever the registered an is 0.
- **Reset values**
  - All outputs 0.
  - p=0, i=0, shadow=0, load-pending=1.
  - Reset applies immediately (asynchronous), including mid-frame. The scan restarts from digit 0 with a fresh snapshot.

## Timing
- Outputs lag the counters by exactly one clk.
- A slot lasts SCAN_DIV cycles; a frame lasts 6·SCAN_DIV cycles.
- In each slot an is 0 for the first GUARD cycles (as seen on the outputs), then one-hot for SCAN_DIV-GUARD cycles.
- After rst release with GUARD=2:
  - edges 1 and 2 leave an=0;
  - edge 3 sets an=000001.
- Input change to display latency:
  - Inputs are captured at the next frame wrap.
  - The new value appears on the target digit at its next active slot.
  - Maximum latency is 12·SCAN_DIV+1 cycles.
- Input changes between snapshots, including a simultaneous carry across several digits, are invisible until the next wrap. Every frame shows digits from a single sample instant.
- GUARD=0: digit enable is never blanked. On the wrap edge the output for digit 0 already reflects the new snapshot.
- Wrap-around of i (5→0) and snapshot load occur on the same edge. No glitch cycle has two enables set.
- an is one-hot or zero on every cycle. seg≠0 never occurs with an=0.

## Test plan
- Bench parameters SCAN_DIV=4, GUARD=1. Inputs hm=2, hl=3, mm=5, ml=9, sm=5, sl=8, lz_blank=0, release rst.
  - Response: over one frame an steps 000001…100000, each high 3 cycles then 1 cycle of 0.
  - seg sequence 7F, 6D, 6F, 6D, 4F, 5B.
  - dp=1 during the ml and hl slots.
- Same bench, change all inputs to 0 mid-frame (during the i=2 slot) → remainder of frame still shows 23:59:58; next frame shows 3F on all six digits.
- hm=0, hl=7, lz_blank=1 → hm slot has an[5]=1 with seg=00. With lz_blank=0 → seg=3F in that slot.
- sl=C (invalid) → sl slot seg=40. sl odd (e.g. 9) → dp=0 in all slots.
- Assert rst low mid-slot at i=3 → an, seg, dp go 0 asynchronously before the next clk edge. After release, scanning restarts at an=000001 on the 2nd edge (GUARD=1) and shows the freshly sampled inputs.
- Random inputs over 50 frames → checker asserts an is zero or one-hot every cycle, and (an==0)⇒seg==0 and dp==0.
